// File: rtl/regfile_wb_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_wb_arbiter
//
// Purpose:
//   Shares the single register-file write port among NREQ writeback requesters
//   (ALU, load unit, mul/div) with a valid/ready handshake. The write accepted
//   in cycle T is driven onto rf_rw/rf_dr/rf_data in cycle T+1. A per-register
//   pending-write scoreboard (busy_vec) lets decode stall on read-after-write
//   hazards for operands A and B.
//
// Configuration macro:
//   RR_ARB_EN  defined   -> round-robin arbitration starting at rr_ptr
//              undefined -> fixed priority, lowest index wins (rr_ptr tied 0)
//
// Ports:
//   clk, rstn            clock (rising edge), asynchronous active-low reset
//   req_valid/req_ready  per-requester handshake; req_ready is one-hot
//   req_dr/req_data      packed per-requester destination index and data
//   rsv_valid/rsv_dr     decode reserves a destination register
//   chk_a/chk_b          operand indices to check; busy_a/busy_b results
//   busy_vec             full scoreboard, bit r = register r write pending
//   rf_rw/rf_dr/rf_data  registered register-file write port
// -----------------------------------------------------------------------------
module regfile_wb_arbiter #(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 16,
    parameter int DEPTH_LOG = $clog2(DEPTH),
    parameter int NREQ      = 3
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic [NREQ-1:0]           req_valid,
    output logic [NREQ-1:0]           req_ready,
    input  logic [NREQ*DEPTH_LOG-1:0] req_dr,
    input  logic [NREQ*WIDTH-1:0]     req_data,
    input  logic                      rsv_valid,
    input  logic [DEPTH_LOG-1:0]      rsv_dr,
    input  logic [DEPTH_LOG-1:0]      chk_a,
    input  logic [DEPTH_LOG-1:0]      chk_b,
    output logic                      busy_a,
    output logic                      busy_b,
    output logic [DEPTH-1:0]          busy_vec,
    output logic                      rf_rw,
    output logic [DEPTH_LOG-1:0]      rf_dr,
    output logic [WIDTH-1:0]          rf_data
);

    localparam int PTR_W = $clog2(NREQ);

    // Grant the first valid requester found when searching upward from
    // start, wrapping NREQ-1 -> 0. With start fixed at 0 this degenerates
    // to lowest-index-wins priority.
    function automatic logic [NREQ-1:0] pick(input logic [NREQ-1:0] v,
                                             input logic [PTR_W-1:0] start);
        logic [NREQ-1:0] g;
        logic            found;
        g     = '0;
        found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            int idx;
            idx = int'(start) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!found && v[idx]) begin
                g[idx] = 1'b1;
                found  = 1'b1;
            end
        end
        return g;
    endfunction

    logic                 rf_rw_q,   rf_rw_d;
    logic [DEPTH_LOG-1:0] rf_dr_q,   rf_dr_d;
    logic [WIDTH-1:0]     rf_data_q, rf_data_d;
    logic [DEPTH-1:0]     busy_q,    busy_d;
    logic [PTR_W-1:0]     rr_ptr;

`ifdef RR_ARB_EN
    logic [PTR_W-1:0]     rr_ptr_q,  rr_ptr_d;
    assign rr_ptr = rr_ptr_q;
`else
    assign rr_ptr = '0;
`endif

    logic                 accept;
    logic [DEPTH_LOG-1:0] win_dr;
    logic [WIDTH-1:0]     win_data;

    // ready may depend on valid: grant is purely combinational.
    assign req_ready = pick(req_valid, rr_ptr);
    assign accept    = |req_ready;

    always_comb begin
        // NOTE: every variable gets a default before any branch so no path
        // leaves it unassigned; a missed assignment here would infer a latch.
        win_dr    = '0;
        win_data  = '0;
        rf_rw_d   = accept;
        rf_dr_d   = rf_dr_q;
        rf_data_d = rf_data_q;
        busy_d    = busy_q;
`ifdef RR_ARB_EN
        rr_ptr_d  = rr_ptr_q;
`endif

        // Grant is one-hot, so OR-ing the masked lanes selects the winner.
        for (int i = 0; i < NREQ; i++) begin
            if (req_ready[i]) begin
                win_dr   = win_dr   | req_dr[i*DEPTH_LOG +: DEPTH_LOG];
                win_data = win_data | req_data[i*WIDTH +: WIDTH];
`ifdef RR_ARB_EN
                rr_ptr_d = PTR_W'((i + 1) % NREQ);
`endif
            end
        end

        // Without an acceptance the index/data hold their last values.
        if (accept) begin
            rf_dr_d   = win_dr;
            rf_data_d = win_data;
        end

        // Clear on commit first, then set on reserve: a new producer
        // reserving the register being committed must keep it busy.
        if (rf_rw_q)   busy_d[rf_dr_q] = 1'b0;
        if (rsv_valid) busy_d[rsv_dr]  = 1'b1;
    end

    // NOTE: the scoreboard is a flop vector rather than a RAM, so it is reset
    // with everything else; an in-flight write and all busy bits are dropped.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rf_rw_q   <= 1'b0;
            rf_dr_q   <= '0;
            rf_data_q <= '0;
            busy_q    <= '0;
`ifdef RR_ARB_EN
            rr_ptr_q  <= '0;
`endif
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values; the
            // busy clear above relies on seeing the old rf_rw_q/rf_dr_q.
            rf_rw_q   <= rf_rw_d;
            rf_dr_q   <= rf_dr_d;
            rf_data_q <= rf_data_d;
            busy_q    <= busy_d;
`ifdef RR_ARB_EN
            rr_ptr_q  <= rr_ptr_d;
`endif
        end
    end

    // Scoreboard lookups read the register only: no same-cycle bypass.
    assign busy_a   = busy_q[chk_a];
    assign busy_b   = busy_q[chk_b];
    assign busy_vec = busy_q;
    assign rf_rw    = rf_rw_q;
    assign rf_dr    = rf_dr_q;
    assign rf_data  = rf_data_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;

    localparam int WIDTH = 32;
    localparam int DEPTH = 16;
    localparam int DL    = 4;
    localparam int NREQ  = 3;

    logic                 clk = 1'b0;
    logic                 rstn;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*DL-1:0]   req_dr;
    logic [NREQ*WIDTH-1:0] req_data;
    logic                 rsv_valid;
    logic [DL-1:0]        rsv_dr;
    logic [DL-1:0]        chk_a;
    logic [DL-1:0]        chk_b;
    logic                 busy_a;
    logic                 busy_b;
    logic [DEPTH-1:0]     busy_vec;
    logic                 rf_rw;
    logic [DL-1:0]        rf_dr;
    logic [WIDTH-1:0]     rf_data;

    regfile_wb_arbiter #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .DEPTH_LOG(DL), .NREQ(NREQ)
    ) dut (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_dr(req_dr), .req_data(req_data),
        .rsv_valid(rsv_valid), .rsv_dr(rsv_dr),
        .chk_a(chk_a), .chk_b(chk_b),
        .busy_a(busy_a), .busy_b(busy_b), .busy_vec(busy_vec),
        .rf_rw(rf_rw), .rf_dr(rf_dr), .rf_data(rf_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DL-1:0]    dr;
        logic [WIDTH-1:0] data;
    } wr_t;

    wr_t              exp_q[$];
    int               n_checks = 0;
    int               n_bad    = 0;
    logic [DEPTH-1:0] m_busy;
    int               m_ptr;
    logic [DL-1:0]    m_dr;
    logic [WIDTH-1:0] m_data;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // Reference arbiter: walk requesters from the model pointer.
    function automatic logic [NREQ-1:0] model_grant();
        logic [NREQ-1:0] g;
        int              start;
        g = '0;
`ifdef RR_ARB_EN
        start = m_ptr;
`else
        start = 0;
`endif
        for (int k = 0; k < NREQ; k++) begin
            int idx;
            idx = (start + k) % NREQ;
            if (req_valid[idx]) begin
                g[idx] = 1'b1;
                break;
            end
        end
        return g;
    endfunction

    task automatic model_reset();
        exp_q.delete();
        m_busy = '0;
        m_ptr  = 0;
        m_dr   = '0;
        m_data = '0;
    endtask

    task automatic set_req(input int i, input logic [DL-1:0] dr, input logic [WIDTH-1:0] data);
        req_dr[i*DL +: DL]         = dr;
        req_data[i*WIDTH +: WIDTH] = data;
    endtask

    task automatic idle_inputs();
        req_valid = '0;
        rsv_valid = 1'b0;
        rsv_dr    = '0;
    endtask

    // One clock: check outputs mid-cycle, advance the model, step past the edge.
    task automatic cycle();
        logic [NREQ-1:0] g;
        wr_t             w;
        logic            commit;
        logic [DL-1:0]   cdr;
        @(negedge clk);
        commit = 1'b0;
        cdr    = '0;
        if (exp_q.size() > 0) begin
            w      = exp_q.pop_front();
            commit = 1'b1;
            cdr    = w.dr;
            m_dr   = w.dr;
            m_data = w.data;
        end
        check("rf_rw",    64'(rf_rw),    64'(commit));
        check("rf_dr",    64'(rf_dr),    64'(m_dr));
        check("rf_data",  64'(rf_data),  64'(m_data));
        check("busy_vec", 64'(busy_vec), 64'(m_busy));
        check("busy_a",   64'(busy_a),   64'(m_busy[chk_a]));
        check("busy_b",   64'(busy_b),   64'(m_busy[chk_b]));
        g = model_grant();
        check("req_ready", 64'(req_ready), 64'(g));
        for (int i = 0; i < NREQ; i++) begin
            if (g[i]) begin
                w.dr   = req_dr[i*DL +: DL];
                w.data = req_data[i*WIDTH +: WIDTH];
                exp_q.push_back(w);
                m_ptr  = (i + 1) % NREQ;
            end
        end
        if (commit)    m_busy[cdr]    = 1'b0;
        if (rsv_valid) m_busy[rsv_dr] = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rstn     = 1'b0;
        req_dr   = '0;
        req_data = '0;
        chk_a    = '0;
        chk_b    = '0;
        idle_inputs();
        model_reset();

        // Reset then idle.
        #3;
        check("rst_rf_rw",    64'(rf_rw),    64'd0);
        check("rst_busy_vec", 64'(busy_vec), 64'd0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        repeat (2) cycle();

        // Single write from requester 1.
        req_valid = 3'b010;
        set_req(1, 4'd5, 32'hDEADBEEF);
        cycle();
        req_valid = '0;
        repeat (2) cycle();

        // Contention: all three valid for three cycles.
        set_req(0, 4'd1, 32'h1111_0000);
        set_req(1, 4'd2, 32'h2222_0000);
        set_req(2, 4'd9, 32'h9999_0000);
        req_valid = 3'b111;
        repeat (3) cycle();
        req_valid = '0;
        repeat (2) cycle();

        // Scoreboard: reserve 7, observe busy, then commit to 7.
        chk_a     = 4'd7;
        chk_b     = 4'd3;
        rsv_valid = 1'b1;
        rsv_dr    = 4'd7;
        cycle();
        rsv_valid = 1'b0;
        cycle();
        req_valid = 3'b100;
        set_req(2, 4'd7, 32'hCAFE_0007);
        cycle();
        req_valid = '0;
        repeat (2) cycle();

        // Collision: reserve 3 in the cycle its previous write commits.
        rsv_valid = 1'b1;
        rsv_dr    = 4'd3;
        cycle();
        rsv_valid = 1'b0;
        req_valid = 3'b001;
        set_req(0, 4'd3, 32'h3333_3333);
        cycle();
        req_valid = '0;
        rsv_valid = 1'b1;
        rsv_dr    = 4'd3;
        cycle();
        rsv_valid = 1'b0;
        repeat (2) cycle();

        // Random traffic.
        for (int n = 0; n < 60; n++) begin
            req_valid = NREQ'($urandom_range(0, 7));
            for (int i = 0; i < NREQ; i++) set_req(i, DL'($urandom_range(0, 15)), $urandom);
            rsv_valid = 1'($urandom_range(0, 1));
            rsv_dr    = DL'($urandom_range(0, 15));
            chk_a     = DL'($urandom_range(0, 15));
            chk_b     = DL'($urandom_range(0, 15));
            cycle();
        end

        // Reset while a write is on the port.
        idle_inputs();
        rsv_valid = 1'b1;
        rsv_dr    = 4'd12;
        req_valid = 3'b010;
        set_req(1, 4'd4, 32'hABCD_1234);
        cycle();
        idle_inputs();
        check("pre_rst_rf_rw", 64'(rf_rw), 64'd1);
        check("pre_rst_busy",  64'(busy_vec[12]), 64'd1);
        rstn = 1'b0;
        #1;
        check("mid_rst_rf_rw", 64'(rf_rw),    64'd0);
        check("mid_rst_busy",  64'(busy_vec), 64'd0);
        check("mid_rst_ready", 64'(req_ready), 64'd0);
        model_reset();
        @(posedge clk);
        #1;
        rstn = 1'b1;
        repeat (2) cycle();

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
